// File: rtl/data_sram_resp_if.sv
// Data-side SRAM request/response bundle between the CPU (master) and
// the SRAM responder (slave).
//   data_sram_en     : request valid this cycle (master -> slave)
//   data_sram_wen    : byte write enables, all-zero means read (master -> slave)
//   data_sram_addr   : byte address (master -> slave)
//   data_sram_wdata  : lane-aligned store data (master -> slave)
//   data_sram_rdata  : registered read data (slave -> master)
//   data_sram_stallreq : access not yet taken, hold the request (slave -> master)
interface data_sram_resp_if;

    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        data_sram_stallreq;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata,
        input  data_sram_stallreq
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata,
        output data_sram_stallreq
    );

endinterface : data_sram_resp_if

// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: word-organised memory with per-byte write
// enables and a registered read port, optionally inserting wait states.
// Optional feature macro: DATA_SRAM_WAIT_EN (enables the wait-state FSM;
// otherwise stallreq is tied low and every request is taken at once).
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset (memory contents are not cleared)
//   bus  : data_sram_resp_if.slave (en/wen/addr/wdata in, rdata/stallreq out)
// Parameters:
//   DEPTH       : memory size in 32-bit words, power of two
//   AW          : word index width, log2(DEPTH)
//   WAIT_CYCLES : wait states per access when DATA_SRAM_WAIT_EN is set, 1..15
module data_sram_resp #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned AW          = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    data_sram_resp_if.slave  bus
);

    localparam int unsigned DW    = 32;
    localparam int unsigned NB    = DW / 8;
    localparam int unsigned CNT_W = 4;

    // Elaboration-time parameter sanity checks
    if (DEPTH != (32'd1 << AW)) begin : g_bad_depth
        $error("data_sram_resp: DEPTH must equal 2**AW");
    end
    if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_bad_wait
        $error("data_sram_resp: WAIT_CYCLES must be in 1..15");
    end

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;
    logic [AW-1:0] idx_c;
    logic          take_c;
    logic          stall_c;
    logic          unused_addr_c;

    // Word index; byte offset and upper bits alias away
    assign idx_c         = bus.data_sram_addr[AW+1:2];
    assign unused_addr_c = ^{bus.data_sram_addr[31:AW+2], bus.data_sram_addr[1:0]};

`ifdef DATA_SRAM_WAIT_EN
    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Wait-state sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, stall request and access-take strobe
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        take_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.data_sram_en) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    stall_c = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    stall_c = 1'b1;
                end else begin
                    // A request withdrawn mid-wait just returns without access
                    state_d = ST_IDLE;
                    take_c  = bus.data_sram_en;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end
`else
    // Zero-wait: every request cycle is a taken access
    always_comb begin
        stall_c = 1'b0;
        take_c  = bus.data_sram_en;
    end
`endif

    // Byte-enabled write; reset has priority and discards the access
    always_ff @(posedge clk) begin
        if (!rst && take_c) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.data_sram_wen[b]) begin
                    mem_q[idx_c][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read port; holds on writes and idle cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (take_c && (bus.data_sram_wen == 4'b0000)) begin
            rdata_q <= mem_q[idx_c];
        end
    end

    assign bus.data_sram_rdata    = rdata_q;
    assign bus.data_sram_stallreq = stall_c;

endmodule : data_sram_resp

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp: directed scenarios plus a
// randomized mix of reads, byte writes and idle cycles checked against a
// word-array reference model. Works with and without DATA_SRAM_WAIT_EN.
module tb_data_sram_resp;

    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned AW      = 10;
    localparam int unsigned WAITS   = 2;
`ifdef DATA_SRAM_WAIT_EN
    localparam int EXP_STALL = WAITS;
`else
    localparam int EXP_STALL = 0;
`endif

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_rdata;

    data_sram_resp_if bus ();

    data_sram_resp #(
        .DEPTH       (DEPTH),
        .AW          (AW),
        .WAIT_CYCLES (WAITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int widx(input logic [31:0] addr);
        return int'((addr / 4) % DEPTH);
    endfunction

    // One request, held until taken; checks stall length and rdata afterwards
    task automatic do_access(input logic [3:0] wen, input logic [31:0] addr,
                             input logic [31:0] wdata, input string tag);
        int stalls;
        stalls = 0;
        bus.data_sram_en    = 1'b1;
        bus.data_sram_wen   = wen;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
        #1;
        while (bus.data_sram_stallreq === 1'b1 && stalls < 20) begin
            stalls++;
            @(posedge clk);
            #2;
        end
        checks++;
        if (stalls != EXP_STALL || bus.data_sram_stallreq !== 1'b0) begin
            errors++;
            $display("FAIL %s stall: got %0d cycles (stallreq=%b) expected %0d",
                     tag, stalls, bus.data_sram_stallreq, EXP_STALL);
        end
        @(posedge clk);
        #1;
        if (wen == 4'b0000) begin
            exp_rdata = ref_mem[widx(addr)];
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (wen[b]) ref_mem[widx(addr)][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        checks++;
        if (bus.data_sram_rdata !== exp_rdata) begin
            errors++;
            $display("FAIL %s rdata: got %08h expected %08h", tag, bus.data_sram_rdata, exp_rdata);
        end
    endtask

    task automatic idle_cycle(input string tag);
        bus.data_sram_en  = 1'b0;
        bus.data_sram_wen = 4'b0000;
        @(posedge clk);
        #1;
        checks++;
        if (bus.data_sram_rdata !== exp_rdata || bus.data_sram_stallreq !== 1'b0) begin
            errors++;
            $display("FAIL %s idle hold: rdata=%08h stallreq=%b expected rdata=%08h stallreq=0",
                     tag, bus.data_sram_rdata, bus.data_sram_stallreq, exp_rdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.data_sram_en    = 1'b0;
        bus.data_sram_wen   = 4'b0000;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_rdata = 32'h0;
        checks++;
        if (bus.data_sram_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset rdata: got %08h expected 00000000", bus.data_sram_rdata);
        end
        checks++;
        if (bus.data_sram_stallreq !== 1'b0) begin
            errors++;
            $display("FAIL reset stallreq: got %b expected 0", bus.data_sram_stallreq);
        end
    endtask

    task automatic test_byte_enable();
        do_access(4'hF, 32'h10, 32'hAABBCCDD, "be_full_write");
        do_access(4'h2, 32'h10, 32'h00001100, "be_lane1_write");
        do_access(4'h0, 32'h10, 32'h0, "be_read");
        checks++;
        if (bus.data_sram_rdata !== 32'hAABB11DD) begin
            errors++;
            $display("FAIL be_value: got %08h expected aabb11dd", bus.data_sram_rdata);
        end
        idle_cycle("be_idle");
    endtask

    task automatic test_alias();
        do_access(4'hF, 32'h1000_0000, 32'h12345678, "alias_write");
        do_access(4'h0, 32'h0000_0000, 32'h0, "alias_read0");
        checks++;
        if (bus.data_sram_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL alias_value0: got %08h expected 12345678", bus.data_sram_rdata);
        end
        idle_cycle("alias_idle");
        do_access(4'h0, 32'h0000_0003, 32'h0, "alias_read3");
        checks++;
        if (bus.data_sram_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL alias_value3: got %08h expected 12345678", bus.data_sram_rdata);
        end
        idle_cycle("alias_idle2");
    endtask

    task automatic test_back_to_back();
        do_access(4'hF, 32'h20, 32'hDEADBEEF, "b2b_write");
        do_access(4'h0, 32'h20, 32'h0, "b2b_read");
        checks++;
        if (bus.data_sram_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL b2b_value: got %08h expected deadbeef", bus.data_sram_rdata);
        end
        // A second back-to-back read pays the full wait again
        do_access(4'h0, 32'h20, 32'h0, "b2b_read2");
        idle_cycle("b2b_idle");
    endtask

    // Reset lands in the second stall cycle (or on the taking cycle with no waits)
    task automatic test_reset_mid_wait();
        do_access(4'hF, 32'h30, 32'h0000_0000, "rmw_clear");
        idle_cycle("rmw_idle");
        bus.data_sram_en    = 1'b1;
        bus.data_sram_wen   = 4'hF;
        bus.data_sram_addr  = 32'h30;
        bus.data_sram_wdata = 32'h55555555;
        repeat ((EXP_STALL > 0) ? EXP_STALL - 1 : 0) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.data_sram_en  = 1'b0;
        bus.data_sram_wen = 4'h0;
        exp_rdata = 32'h0;
        #1;
        checks++;
        if (bus.data_sram_stallreq !== 1'b0 || bus.data_sram_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rmw_after_reset: stallreq=%b rdata=%08h expected 0/00000000",
                     bus.data_sram_stallreq, bus.data_sram_rdata);
        end
        @(posedge clk);
        #1;
        do_access(4'h0, 32'h30, 32'h0, "rmw_read");
        checks++;
        if (bus.data_sram_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rmw_value: got %08h expected 00000000", bus.data_sram_rdata);
        end
        idle_cycle("rmw_idle2");
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [31:0] idx;
        int          op;
        for (int i = 0; i < 16; i++) begin
            do_access(4'hF, 32'h100 + 32'(i * 4), $urandom(), "rnd_init");
        end
        for (int n = 0; n < 250; n++) begin
            idx  = 32'h40 + 32'($urandom_range(0, 15));
            addr = ($urandom() & ~32'h0000_0FFC) | (idx << 2);
            op   = int'($urandom_range(0, 9));
            if (op < 2) begin
                idle_cycle("rnd_idle");
            end else if (op < 6) begin
                do_access(4'h0, addr, $urandom(), "rnd_read");
            end else begin
                do_access(4'($urandom_range(1, 15)), addr, $urandom(), "rnd_write");
            end
        end
        idle_cycle("rnd_end");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        test_reset();
        test_byte_enable();
        test_alias();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_data_sram_resp

// File: doc/data_sram_resp.md
# data_sram_resp

- Data-side SRAM responder for the five-stage CPU.
- The CPU's EX stage drives the request (`data_sram_en`, `data_sram_wen`, `data_sram_addr`, `data_sram_wdata`). The MEM stage consumes `data_sram_rdata` one cycle after the access is taken.
- The block holds a word-organised memory with per-byte write enables and a registered read port.
- It can optionally insert wait states via `stallreq`, which feeds the CTRL stall logic.
- It sits beside the CPU top in the SoC wrapper and replaces the external data SRAM for simulation and FPGA bring-up.

## Interface
- `DEPTH`, default 1024: memory size in 32-bit words; must be a power of two.
- `AW`, default 10: index width, equal to log2(DEPTH).
- `WAIT_CYCLES`, default 2: wait states per access when `DATA_SRAM_WAIT_EN` is defined; legal range 1..15.

- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `data_sram_en`, input, 1: request valid this cycle.
- `data_sram_wen`, input, 4: byte write enables. Bit i writes `wdata[8i+7:8i]`. All-zero means read.
- `data_sram_addr`, input, 32: byte address. Word index is `addr[AW+1:2]`. `addr[1:0]` and `addr[31:AW+2]` are ignored.
- `data_sram_wdata`, input, 32: store data, already byte-lane aligned by EX.
- `data_sram_rdata`, output, 32: registered read data.
- `stallreq`, output, 1: access not yet taken; CTRL must hold EX→MEM.

## Operation
**Access taken.** An access is taken in a cycle when `data_sram_en`=1 and `stallreq`=0.
- **Write** (`wen`≠0): at the edge, only the enabled bytes of `mem[idx]` are updated. `data_sram_rdata` holds its previous value.
- **Read** (`wen`=0): at the edge, `data_sram_rdata <= mem[idx]`.
- **No request**: when `data_sram_en`=0, memory and `data_sram_rdata` hold.

**Addressing.**
- Addresses alias modulo DEPTH words; there is no error response.
- Read-after-write to the same word in consecutive taken accesses returns the new data. The write is committed before the next read edge, so no bypass is needed.

**Memory contents.** Memory is not cleared by `rst`; initial contents are X. Tests must write before reading.

**Wait-state FSM** (only when `DATA_SRAM_WAIT_EN` is defined):
- States are IDLE and WAIT, plus a 4-bit counter `cnt`.
- `stallreq = (IDLE && en) || (WAIT && cnt != 0)`, combinational.
- IDLE with `en`=1: go to WAIT, `cnt <= WAIT_CYCLES-1`. Nothing is written or read.
- WAIT with `cnt` != 0: `cnt <= cnt-1`.
- WAIT with `cnt` == 0: the access is taken at this edge, then the FSM returns to IDLE.
- The CPU holds the request stable while `stallreq`=1. The block samples the request only in the taking cycle.
- Back-to-back requests each pay the full wait: IDLE re-enters WAIT on the cycle after return.
- `en` dropping while in WAIT: the FSM still counts down, and at `cnt`==0 it returns to IDLE without any access.

## Timing
- Reset values: `data_sram_rdata`=0, `stallreq`=0, FSM=IDLE, `cnt`=0.
- Read latency is 1 cycle from the taking edge: the data is visible in the cycle MEM consumes it.
- Without wait states, `stallreq` is constantly 0 and every `en` cycle is a taken access.
- With wait states, a request is held for WAIT_CYCLES+1 cycles. `stallreq` is high for the first WAIT_CYCLES of them.
- Reset during WAIT: the FSM returns to IDLE and `stallreq` drops the next cycle. The pending write is discarded and memory is unchanged. `data_sram_rdata` goes to 0.
- `rst` has priority over any simultaneous access.

## Configuration
- `DATA_SRAM_WAIT_EN` defined: the wait-state FSM and `cnt` are compiled in, and `stallreq` behaves as above.
- `DATA_SRAM_WAIT_EN` undefined: there is no FSM or counter, `stallreq` is tied to 0, and every access completes with zero wait states.

## Test plan
- **Reset:** assert `rst` for 2 cycles. Expect `data_sram_rdata`=0 and `stallreq`=0 in the cycle after release.
- **Byte-enable write, then read** (no wait): write 0xAABBCCDD to 0x10 with `wen`=0xF, then `wen`=0x2 with `wdata`=0x00001100. Read 0x10 and expect 0xAABB11DD one cycle later.
- **Aliasing:** with DEPTH=1024, write 0x12345678 to 0x1000_0000, then read 0x0000_0000. Expect 0x12345678. A read of 0x0000_0003 returns the same word.
- **Read-after-write back-to-back:** write 0xDEADBEEF to 0x20, then read 0x20 on the very next cycle. Expect 0xDEADBEEF the cycle after that. `rdata` is unchanged during the write cycle.
- **Wait states** (`DATA_SRAM_WAIT_EN`, WAIT_CYCLES=2): hold a read of 0x20 for 3 cycles. Expect `stallreq`=1,1,0, with 0xDEADBEEF on `rdata` in cycle 4. A second back-to-back request gives the same 1,1,0 pattern.
- **Reset mid-wait:** issue a write of 0x55555555 to 0x30 (previously 0x0) and assert `rst` in the second stall cycle. Expect `stallreq`=0 after reset, and a later read of 0x30 returns 0x0.
